// File: rtl/decode_if.sv
// Fetch-to-decode and decode-to-register-read handshake bundle for decode_stage.
interface decode_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_opcode;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [4:0]      out_shamt;
  logic [5:0]      out_funct;
  logic [1:0]      out_type;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_jaddr;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
           out_funct, out_type, out_imm, out_jaddr, out_pc, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
           out_funct, out_type, out_imm, out_jaddr, out_pc, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Registered MIPS decode stage with a 2-entry skid buffer and flush.
// Define DECODE_ILLEGAL_CHECK_EN to build the unsupported-opcode flag.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    flush,
  decode_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [5:0]      opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      funct;
    logic [1:0]      typ;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] jaddr;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  state_t          state, state_nxt;
  entry_t          head, skid, dec;
  logic            in_xfer, out_xfer;
  logic            ld_head_in, ld_skid, ld_head_skid;
  logic [XLEN-1:0] pc4;
  logic [31:0]     imm32;
  logic            imm_fill;
  logic            unused_pc4;

  assign unused_pc4 = ^pc4[27:0];

  // Decode happens on the incoming instruction so stored entries are ready to drive out.
  always_comb begin
    dec        = '0;
    dec.opcode = bus.in_instr[31:26];
    dec.rs     = bus.in_instr[25:21];
    dec.rt     = bus.in_instr[20:16];
    dec.rd     = bus.in_instr[15:11];
    dec.shamt  = bus.in_instr[10:6];
    dec.funct  = bus.in_instr[5:0];
    dec.pc     = bus.in_pc;

    unique case (dec.opcode)
      6'h00:        dec.typ = 2'd0;
      6'h02, 6'h03: dec.typ = 2'd2;
      default:      dec.typ = 2'd1;
    endcase

    unique case (dec.opcode)
      6'h0C, 6'h0D, 6'h0E: begin
        imm32    = {16'h0000, bus.in_instr[15:0]};
        imm_fill = 1'b0;
      end
      6'h0F: begin
        imm32    = {bus.in_instr[15:0], 16'h0000};
        imm_fill = bus.in_instr[15];
      end
      default: begin
        imm32    = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
        imm_fill = bus.in_instr[15];
      end
    endcase
    dec.imm       = {XLEN{imm_fill}};
    dec.imm[31:0] = imm32;

    pc4                     = bus.in_pc + XLEN'(4);
    dec.jaddr               = '0;
    dec.jaddr[XLEN-1:28]    = pc4[XLEN-1:28];
    dec.jaddr[27:0]         = {bus.in_instr[25:0], 2'b00};

`ifdef DECODE_ILLEGAL_CHECK_EN
    unique case (dec.opcode)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
      6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: dec.illegal = 1'b0;
      default:                                  dec.illegal = 1'b1;
    endcase
`else
    dec.illegal = 1'b0;
`endif
  end

  always_comb begin
    bus.in_ready  = (state != TWO);
    bus.out_valid = (state != EMPTY);
    in_xfer       = bus.in_valid && bus.in_ready;
    out_xfer      = bus.out_valid && bus.out_ready;
    state_nxt     = state;
    ld_head_in    = 1'b0;
    ld_skid       = 1'b0;
    ld_head_skid  = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt  = ONE;
          ld_head_in = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          ld_head_in = 1'b1;
        end else if (in_xfer) begin
          state_nxt = TWO;
          ld_skid   = 1'b1;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_nxt    = ONE;
          ld_head_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
      if (ld_head_in)   head <= dec;
      if (ld_head_skid) head <= skid;
      if (ld_skid)      skid <= dec;
    end
  end

  assign bus.out_opcode  = head.opcode;
  assign bus.out_rs      = head.rs;
  assign bus.out_rt      = head.rt;
  assign bus.out_rd      = head.rd;
  assign bus.out_shamt   = head.shamt;
  assign bus.out_funct   = head.funct;
  assign bus.out_type    = head.typ;
  assign bus.out_imm     = head.imm;
  assign bus.out_jaddr   = head.jaddr;
  assign bus.out_pc      = head.pc;
  assign bus.out_illegal = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors with hand-computed decode results.
module tb_decode_stage;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [1:0]  typ;
    logic [31:0] imm;
    logic [31:0] jaddr;
    logic [31:0] pc;
    logic        illegal;
  } exp_t;

`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif

  localparam logic [31:0] VI [7] = '{32'h012A4020, 32'h2008FFFF, 32'h3508FFFF, 32'h08000010,
                                     32'h3C01ABCD, 32'h29018000, 32'hFC000000};
  localparam logic [31:0] VP [7] = '{32'h00400000, 32'h00400004, 32'h00400008, 32'h40000000,
                                     32'hFFFFFFFC, 32'h00000000, 32'h00000100};
  localparam logic [1:0]  VT [7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1};
  localparam logic [31:0] VM [7] = '{32'h00004020, 32'hFFFFFFFF, 32'h0000FFFF, 32'h00000010,
                                     32'hABCD0000, 32'hFFFF8000, 32'h00000000};
  localparam logic [31:0] VJ [7] = '{32'h04A90080, 32'h0023FFFC, 32'h0423FFFC, 32'h40000040,
                                     32'h0006AF34, 32'h04060000, 32'h00000000};
  localparam bit          VL [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ILL};

  logic clk = 1'b0;
  logic reset, flush;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t act;

  decode_if #(.XLEN(32)) bus ();

  decode_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    act = {bus.out_opcode, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt, bus.out_funct,
           bus.out_type, bus.out_imm, bus.out_jaddr, bus.out_pc, bus.out_illegal};
  end

  function automatic exp_t mk(input int idx);
    exp_t e;
    logic [31:0] w;
    w         = VI[idx];
    e.opcode  = w[31:26];
    e.rs      = w[25:21];
    e.rt      = w[20:16];
    e.rd      = w[15:11];
    e.shamt   = w[10:6];
    e.funct   = w[5:0];
    e.typ     = VT[idx];
    e.imm     = VM[idx];
    e.jaddr   = VJ[idx];
    e.pc      = VP[idx];
    e.illegal = VL[idx];
    return e;
  endfunction

  task automatic chk(input string name, input logic [255:0] a, input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, a, e);
    end
  endtask

  // Monitor: every accepted output is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && !flush && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output actual=%0h required=none", act);
      end else begin
        chk("entry", 256'(act), 256'(q.pop_front()));
      end
    end
  end

  task automatic send(input int idx);
    bit acc;
    acc          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = VI[idx];
    bus.in_pc    = VP[idx];
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(mk(idx));
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=in_ready_low required=accept vec=%0d", idx);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 256'(bus.in_ready), 256'(1));
    chk("reset_out_valid", 256'(bus.out_valid), 256'(0));
    chk("reset_fields", 256'(act), 256'(0));
    @(posedge clk);
    #1;

    // Streaming decode with a one-cycle latency check on the first entry
    bus.out_ready = 1'b1;
    send(0);
    @(negedge clk);
    chk("latency_valid", 256'(bus.out_valid), 256'(1));
    @(posedge clk);
    #1;
    for (int i = 1; i < 6; i++) send(i);
    wait_drain();

    // Backpressure: two absorbed, third must wait, order preserved
    bus.out_ready = 1'b0;
    send(0);
    @(negedge clk);
    chk("bp_one_ready", 256'(bus.in_ready), 256'(1));
    @(posedge clk);
    #1;
    send(1);
    @(negedge clk);
    chk("bp_full_ready", 256'(bus.in_ready), 256'(0));
    chk("bp_full_valid", 256'(bus.out_valid), 256'(1));
    repeat (3) @(negedge clk);
    chk("bp_hold", 256'(act), 256'(q[0]));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(2);
    send(3);
    wait_drain();

    // Flush in TWO with a simultaneous offer
    bus.out_ready = 1'b0;
    send(4);
    send(5);
    bus.in_valid = 1'b1;
    bus.in_instr = VI[0];
    bus.in_pc    = VP[0];
    flush        = 1'b1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("flush_out_valid", 256'(bus.out_valid), 256'(0));
    chk("flush_in_ready", 256'(bus.in_ready), 256'(1));
    @(posedge clk);
    #1;

    // Unsupported opcode after flush; the flushed offer must not reappear
    bus.out_ready = 1'b1;
    send(6);
    wait_drain();
    repeat (5) @(posedge clk);
    #1;
    chk("idle_out_valid", 256'(bus.out_valid), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
